pulse_sequencer: RTL and testbench
==================================

// Module: pulse_sequencer
// PURPOSE
//   Controller for the periodic-pulse timebase. Replays a programmable table of up to DEPTH
//   periods: one single-cycle pulse per step, then advance to the next step.
//   Stops at the end of the table, or loops back to step 0.
//   Sits between the configuration logic (table writes, start/stop) and downstream consumers of
//   `out`, such as sample strobes, LED/PWM steppers and scan drivers.
//   Period semantics: a table value T gives T+1 enabled cycles per pulse. Count runs 0..T; the
//   pulse fires when count==T.
// PARAMETERS
//   N      8                  width of tick count and table entries
//   DEPTH  4                  number of table entries (>=2)
//   AW     $clog2(DEPTH)      table index width (derived; do not override)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst        in   1   asynchronous, active-high reset
//   cfg_we     in   1   table write strobe
//   cfg_addr   in   AW  table write index
//   cfg_ticks  in   N   table write data (period value T)
//   last       in   AW  index of the final step; sampled at start
//   loop       in   1   1 = wrap to step 0 after last; sampled at start
//   start      in   1   begin sequence (level sampled each cycle)
//   stop       in   1   abort sequence
//   ena        in   1   tick enable; count advances only when high
//   out        out  1   registered single-cycle pulse
//   step       out  AW  current step index
//   busy       out  1   high in RUN
//   done       out  1   one-cycle pulse when a non-looping sequence completes
//   cfg_err    out  1   one-cycle pulse when a table write is dropped because busy
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; table entries, count, step, out, busy, done and
//     cfg_err all = 0. Latched last/loop = 0.
//   States: IDLE, RUN.
//   IDLE:
//     - cfg_we=1 writes table[cfg_addr] <= cfg_ticks.
//     - start=1 & stop=0 -> RUN. Sets count<=0, step<=0, and latches last/loop.
//     - out=0, busy=0.
//   RUN (busy=1), evaluated each edge in priority order:
//     1. stop=1: -> IDLE; count<=0, step<=0; out=0 that cycle. done is NOT asserted.
//     2. ena=0: hold count and step; out<=0.
//     3. ena=1 & count!=table[step]: count<=count+1; out<=0.
//     4. ena=1 & count==table[step]: out<=1; count<=0.
//        - step<last: step<=step+1.
//        - step==last & loop=1: step<=0.
//        - step==last & loop=0: -> IDLE, step<=0, done<=1. done and the final out are high
//          in the same cycle.
//   Latency: out rises on the edge after the cycle where an enabled count equals table[step].
//     With ena held high, the first pulse arrives table[0]+1 cycles after the start edge.
//   T=0: pulse on every enabled cycle. T=2^N-1: count reaches the max without wrap, then clears.
//   A latched last >= DEPTH is clamped to DEPTH-1.
//   start while in RUN is ignored (no restart). start and stop together in IDLE: stay IDLE.
//   cfg_we while busy: the write is dropped and cfg_err pulses for 1 cycle. The table is never
//     modified in RUN.
//   The table uses the value current at compare time. Since writes are blocked in RUN, the
//     sequence is deterministic.
//   Reset asserted mid-RUN: all outputs drop to 0 immediately (asynchronously). The table is
//     cleared, so it must be reprogrammed.
//   out, done and cfg_err are never high for 2 consecutive cycles, except out when T=0.
// TESTING
//   1. Program table={2,0,3,1}, last=3, loop=0, ena=1, start -> out pulses at cycles 3,4,8,10
//      after the start edge. done high with the last pulse, then busy=0.
//   2. Same table with loop=1 -> pulse pattern repeats with a period of 10 cycles, and step
//      wraps 3->0. Assert stop mid-step -> busy=0 next cycle, done never high.
//   3. table[0]=4, last=0, ena toggling 1,0,1,0... -> pulse after 5 enabled cycles
//      (10 clocks). count holds while ena=0.
//   4. cfg_we to addr 1 during RUN -> cfg_err=1 for one cycle, table[1] unchanged (re-read it
//      after return to IDLE by running with last=1).
//   5. Assert rst asynchronously mid-count -> out/busy/step read 0 before the next clk edge.
//      After release, start with an unprogrammed table -> out pulses every cycle for last+1
//      cycles.
//   6. N=8, table[0]=255, last=0, loop=0 -> a single pulse at cycle 256, no count wrap.
//      start and stop together in IDLE -> busy stays 0.

Source files
------------

// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
//   Periodic-pulse timebase controller. Replays a table of up to DEPTH period
//   values. A table value T gives T+1 enabled cycles per pulse: the tick count
//   runs 0..T and a single-cycle pulse is registered when count==T. After each
//   pulse the sequencer advances to the next step. At the final step it either
//   stops (pulsing done) or wraps to step 0.
//
// Ports
//   clk        in   1    clock, all state updates on posedge
//   rst        in   1    asynchronous active-high reset
//   cfg_we     in   1    table write strobe (honoured only when idle)
//   cfg_addr   in   AW   table write index
//   cfg_ticks  in   N    table write data (period value T)
//   last       in   AW   index of the final step, sampled at start
//   loop       in   1    1 = wrap to step 0 after last, sampled at start
//   start      in   1    begin a sequence (level, ignored while running)
//   stop       in   1    abort the running sequence
//   ena        in   1    tick enable
//   out        out  1    registered single-cycle pulse
//   step       out  AW   current step index
//   busy       out  1    high while running
//   done       out  1    one-cycle pulse when a non-looping sequence completes
//   cfg_err    out  1    one-cycle pulse when a table write is dropped (busy)
// -----------------------------------------------------------------------------
module pulse_sequencer #(
    parameter  int N     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_ticks,
    input  logic [AW-1:0] last,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    input  logic          ena,
    output logic          out,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [N-1:0]  r_table [DEPTH];
    logic [N-1:0]  r_count;
    logic [AW-1:0] r_step;
    logic [AW-1:0] r_last;
    logic          r_loop;
    logic          r_out;
    logic          r_done;
    logic          r_cfg_err;

    logic [AW-1:0] w_last_clamped;
    logic [N-1:0]  w_period;
    logic          w_hit;

    // A last index beyond the table can only occur when DEPTH is not a
    // power of two; otherwise every AW-bit value is a valid step.
    generate
        if (DEPTH == (1 << AW)) begin : g_no_clamp
            assign w_last_clamped = last;
        end else begin : g_clamp
            localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);
            assign w_last_clamped = (last > LAST_MAX) ? LAST_MAX : last;
        end
    endgenerate

    assign w_period = r_table[r_step];
    assign w_hit    = (r_count == w_period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_step    <= '0;
            r_last    <= '0;
            r_loop    <= 1'b0;
            r_out     <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            // Pulse outputs default low so each can only last one cycle.
            r_out     <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        r_table[cfg_addr] <= cfg_ticks;
                    end
                    if (start && !stop) begin
                        r_state <= ST_RUN;
                        r_count <= '0;
                        r_step  <= '0;
                        r_last  <= w_last_clamped;
                        r_loop  <= loop;
                    end
                end
                ST_RUN: begin
                    if (cfg_we) begin
                        r_cfg_err <= 1'b1;
                    end
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_step  <= '0;
                    end else if (ena) begin
                        if (!w_hit) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_out   <= 1'b1;
                            r_count <= '0;
                            if (r_step != r_last) begin
                                r_step <= r_step + 1'b1;
                            end else if (r_loop) begin
                                r_step <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_step  <= '0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign out     = r_out;
    assign step    = r_step;
    assign busy    = (r_state == ST_RUN);
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer. Expected per-cycle outputs are derived
// from the table contents the bench has written ("T+1 enabled cycles per
// pulse") and queued before each run, then popped and compared cycle by cycle.
module tb_pulse_sequencer;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [N-1:0]  cfg_ticks = '0;
    logic [AW-1:0] last = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ena = 1'b0;
    logic          out;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;
    logic          cfg_err;

    pulse_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_ticks(cfg_ticks),
        .last     (last),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .ena      (ena),
        .out      (out),
        .step     (step),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          o;
        logic          d;
        logic          b;
        logic [AW-1:0] s;
    } exp_t;

    exp_t q[$];
    int   exp_tab[DEPTH];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ena always high; mode 1: ena high only on even cycles after start
    function automatic logic ena_pat(input int mode, input int c);
        return (mode == 0) ? 1'b1 : (c % 2 == 0);
    endfunction

    task automatic wr(input int a, input int v);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_ticks = N'(v);
        tick();
        cfg_we = 1'b0;
        exp_tab[a] = v;
        chk($sformatf("cfg_err_idle_wr%0d", a), 32'(cfg_err), 32'd0);
    endtask

    // Each step consumes T+1 enabled cycles, the last of which carries the pulse.
    task automatic gen(input int lst, input bit lp, input int mode, input int k);
        int   st;
        int   rem;
        bit   running;
        exp_t e;
        st = 0;
        rem = exp_tab[0] + 1;
        running = 1'b1;
        for (int c = 1; c <= k; c++) begin
            e = '0;
            if (running && ena_pat(mode, c)) begin
                rem--;
                if (rem == 0) begin
                    e.o = 1'b1;
                    if (st < lst) begin
                        st++;
                    end else if (lp) begin
                        st = 0;
                    end else begin
                        st = 0;
                        running = 1'b0;
                        e.d = 1'b1;
                    end
                    rem = exp_tab[st] + 1;
                end
            end
            e.b = running;
            e.s = AW'(st);
            q.push_back(e);
        end
    endtask

    task automatic run_seq(input string tag, input int lst, input bit lp, input int mode, input int k);
        exp_t e;
        last  = AW'(lst);
        loop  = lp;
        ena   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_busy"}, 32'(busy), 32'd1);
        gen(lst, lp, mode, k);
        for (int c = 1; c <= k; c++) begin
            ena = ena_pat(mode, c);
            tick();
            e = q.pop_front();
            chk($sformatf("%s_out_c%0d", tag, c),  32'(out),  32'(e.o));
            chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(e.d));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(e.b));
            chk($sformatf("%s_step_c%0d", tag, c), 32'(step), 32'(e.s));
        end
        ena = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_tab[i] = 0;

        // Reset state
        tick();
        tick();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        tick();

        // 1: table {2,0,3,1}, one-shot: pulses at 3,4,8,10, done with the last
        wr(0, 2);
        wr(1, 0);
        wr(2, 3);
        wr(3, 1);
        run_seq("t1", 3, 1'b0, 0, 14);

        // 2: looping, then stop mid-step
        run_seq("t2", 3, 1'b1, 0, 25);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stop_busy", 32'(busy), 32'd0);
        chk("t2_stop_out", 32'(out), 32'd0);
        chk("t2_stop_done", 32'(done), 32'd0);
        chk("t2_stop_step", 32'(step), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t2_after_done_%0d", i), 32'(done), 32'd0);
            chk($sformatf("t2_after_out_%0d", i), 32'(out), 32'd0);
        end

        // 3: T=4 with ena toggling -> pulse after 5 enabled cycles (10 clocks)
        wr(0, 4);
        run_seq("t3", 0, 1'b0, 1, 12);

        // 4: write during RUN is dropped with a cfg_err pulse
        last  = 2'd1;
        loop  = 1'b1;
        ena   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cfg_we    = 1'b1;
        cfg_addr  = 2'd1;
        cfg_ticks = 8'd7;
        tick();
        cfg_we = 1'b0;
        chk("t4_cfg_err_hi", 32'(cfg_err), 32'd1);
        tick();
        chk("t4_cfg_err_lo", 32'(cfg_err), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_busy", 32'(busy), 32'd0);
        run_seq("t4", 1, 1'b0, 0, 8);

        // 5: async reset while the pulse of step 0 is out
        last  = 2'd3;
        loop  = 1'b0;
        ena   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("t5_pre_out", 32'(out), 32'd1);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        chk("t5_pre_step", 32'(step), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_out", 32'(out), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_step", 32'(step), 32'd0);
        chk("t5_async_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_tab[i] = 0;
        tick();
        run_seq("t5", 3, 1'b0, 0, 6);

        // 6: T=255 -> single pulse at cycle 256
        wr(0, 255);
        run_seq("t6", 0, 1'b0, 0, 258);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chk("t6_startstop_busy", 32'(busy), 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        tick();
        chk("t6_startstop_busy2", 32'(busy), 32'd0);
        chk("t6_startstop_out", 32'(out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
